// File: rtl/button_conditioner_pkg.sv
// Shared types and helpers for the button conditioning front end.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        BTN  = 2'd2
    } state_t;

    // Bits needed to hold values 0..max_value, never less than one bit.
    function automatic int count_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/debouncer.sv
// One-bit synchronizer and debouncer with registered press/release pulses.
module debouncer
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120_000
) (
    input  logic clk,
    input  logic rst,
    input  logic button_raw,
    output logic button_clean,
    output logic pressed,
    output logic released
);

    localparam int              CNT_W    = count_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync;
    logic [CNT_W-1:0] cnt;

    // NOTE: every flop here uses <= so all of them sample the pre-edge values together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_meta    <= 1'b0;
            sync         <= 1'b0;
            cnt          <= '0;
            button_clean <= 1'b0;
            pressed      <= 1'b0;
            released     <= 1'b0;
        end else begin
            sync_meta <= button_raw;
            sync      <= sync_meta;
            pressed   <= 1'b0;
            released  <= 1'b0;
            // Any agreeing sample restarts the run, so short glitches never reach terminal count.
            if (sync == button_clean) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                button_clean <= sync;
                cnt          <= '0;
                pressed      <= sync;
                released     <= ~sync;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Debounces the board buttons and sequences the core reset from power-up and button 0.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int N_BUTTONS         = 2,
    parameter int DEBOUNCE_CYCLES   = 120_000,
    parameter int RESET_HOLD_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BUTTONS-1:0] buttons_raw,
    output logic [N_BUTTONS-1:0] buttons_clean,
    output logic [N_BUTTONS-1:0] pressed,
    output logic [N_BUTTONS-1:0] released,
    output logic                 core_rst
);

    localparam int               HOLD_W    = count_width(RESET_HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

    state_t             state;
    state_t             state_next;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [HOLD_W-1:0]  hold_cnt_next;
    logic               core_rst_next;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
        debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk         (clk),
            .rst         (rst),
            .button_raw  (buttons_raw[i]),
            .button_clean(buttons_clean[i]),
            .pressed     (pressed[i]),
            .released    (released[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= HOLD;
            hold_cnt <= '0;
            core_rst <= 1'b1;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
            core_rst <= core_rst_next;
        end
    end

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            HOLD: begin
                // A held button outranks the hold timer expiring in the same cycle.
                if (buttons_clean[0])           state_next = BTN;
                else if (hold_cnt == HOLD_LAST) state_next = RUN;
            end
            RUN:     if (buttons_clean[0])  state_next = BTN;
            BTN:     if (!buttons_clean[0]) state_next = HOLD;
            default: state_next = HOLD;
        endcase
    end

    // Registered decode of the next state keeps core_rst aligned with state.
    always_comb begin
        hold_cnt_next = '0;
        if (state == HOLD && state_next == HOLD) hold_cnt_next = hold_cnt + HOLD_W'(1);
        core_rst_next = (state_next != RUN);
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench: directed scenarios plus random stimulus against a history-based model.
module tb_button_conditioner;

    localparam int N = 2;
    localparam int D = 4;
    localparam int R = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] buttons_raw = '0;
    logic [N-1:0] buttons_clean;
    logic [N-1:0] pressed;
    logic [N-1:0] released;
    logic         core_rst;

    int checks   = 0;
    int failures = 0;

    button_conditioner #(
        .N_BUTTONS        (N),
        .DEBOUNCE_CYCLES  (D),
        .RESET_HOLD_CYCLES(R)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .buttons_raw  (buttons_raw),
        .buttons_clean(buttons_clean),
        .pressed      (pressed),
        .released     (released),
        .core_rst     (core_rst)
    );

    always #5 clk = ~clk;

    // Model: clean level flips when the last D synchronized samples all disagree with it;
    // core_rst drops after enough consecutive edges that saw button 0 clean-low.
    logic [N-1:0] raw_hist[$];
    logic [N-1:0] m_clean, m_pressed, m_released;
    logic         m_core;
    int           quiet;
    bit           seen_btn;

    function automatic logic samp(input int x, input int i);
        if (x < 0) return 1'b0;
        return raw_hist[x][i];
    endfunction

    task automatic model_reset();
        raw_hist.delete();
        m_clean = '0; m_pressed = '0; m_released = '0;
        m_core = 1'b1; quiet = 0; seen_btn = 1'b0;
    endtask

    task automatic model_edge();
        logic c0;
        int   t;
        bit   flip;
        c0 = m_clean[0];
        raw_hist.push_back(buttons_raw);
        t = raw_hist.size() - 1;
        m_pressed = '0; m_released = '0;
        for (int i = 0; i < N; i++) begin
            flip = 1'b1;
            for (int j = 0; j < D; j++) if (samp(t - 2 - j, i) == m_clean[i]) flip = 1'b0;
            if (flip) begin
                m_clean[i] = ~m_clean[i];
                if (m_clean[i]) m_pressed[i] = 1'b1;
                else            m_released[i] = 1'b1;
            end
        end
        if (c0) begin quiet = 0; seen_btn = 1'b1; end
        else quiet++;
        m_core = (quiet < (seen_btn ? R + 1 : R));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [6:0] got, exp;
        rst = 1'b0; buttons_raw = 2'b11;
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            got = {buttons_clean, pressed, released, core_rst};
            checks++;
            if (got !== 7'b0000001) begin
                failures++; $display("FAIL reset_hold cyc=%0d got=%b exp=%b", e, got, 7'b0000001);
            end
        end
        buttons_raw = 2'b00; rst = 1'b1;
        model_reset();
        for (int e = 0; e < 6; e++) begin
            cycle();
            got = {buttons_clean, pressed, released, core_rst};
            exp = {m_clean, m_pressed, m_released, m_core};
            checks++;
            if (got !== exp) begin
                failures++; $display("FAIL reset_model cyc=%0d got=%b exp=%b", e, got, exp);
            end
            checks++;
            if (core_rst !== (e < R - 1)) begin
                failures++; $display("FAIL reset_release edge=%0d core_rst=%b exp=%b", e, core_rst, (e < R - 1));
            end
        end
    endtask

    task automatic test_clean_press();
        logic [6:0] got, exp;
        for (int phase = 0; phase < 2; phase++) begin
            buttons_raw[1] = (phase == 0);
            for (int e = 0; e < 10; e++) begin
                cycle();
                got = {buttons_clean, pressed, released, core_rst};
                exp = {m_clean, m_pressed, m_released, m_core};
                checks++;
                if (got !== exp) begin
                    failures++; $display("FAIL press_model ph=%0d cyc=%0d got=%b exp=%b", phase, e, got, exp);
                end
                checks++;
                if (phase == 0 && ({buttons_clean[1], pressed[1], released[1]} !== {e >= D + 1, e == D + 1, 1'b0})) begin
                    failures++; $display("FAIL press_timing cyc=%0d clean/p/r=%b%b%b", e, buttons_clean[1], pressed[1], released[1]);
                end
                if (phase == 1 && ({buttons_clean[1], pressed[1], released[1]} !== {e < D + 1, 1'b0, e == D + 1})) begin
                    failures++; $display("FAIL release_timing cyc=%0d clean/p/r=%b%b%b", e, buttons_clean[1], pressed[1], released[1]);
                end
            end
        end
    endtask

    task automatic test_bounce();
        logic [6:0] got, exp;
        int np, nr;
        for (int rep = 0; rep < 5; rep++) begin
            for (int c = 0; c < 4; c++) begin
                buttons_raw[1] = (c < 3);
                cycle();
                checks++;
                if ({buttons_clean[1], pressed[1], released[1]} !== 3'b000) begin
                    failures++; $display("FAIL bounce rep=%0d c=%0d clean/p/r=%b%b%b exp=000", rep, c, buttons_clean[1], pressed[1], released[1]);
                end
            end
        end
        np = 0; nr = 0;
        for (int e = 0; e < 14; e++) begin
            buttons_raw[1] = (e < D);
            cycle();
            got = {buttons_clean, pressed, released, core_rst};
            exp = {m_clean, m_pressed, m_released, m_core};
            checks++;
            if (got !== exp) begin
                failures++; $display("FAIL pulse_model cyc=%0d got=%b exp=%b", e, got, exp);
            end
            np += int'(pressed[1]); nr += int'(released[1]);
        end
        checks++;
        if (np !== 1 || nr !== 1) begin
            failures++; $display("FAIL pulse_pass pressed=%0d released=%0d exp=1/1", np, nr);
        end
    endtask

    task automatic test_button_reset();
        logic [6:0] got, exp;
        int rc, cr, fc, cf;
        rc = -1; cr = -1; fc = -1; cf = -1;
        for (int e = 0; e < 26; e++) begin
            buttons_raw[0] = (e < 10);
            cycle();
            got = {buttons_clean, pressed, released, core_rst};
            exp = {m_clean, m_pressed, m_released, m_core};
            checks++;
            if (got !== exp) begin
                failures++; $display("FAIL btnrst_model cyc=%0d got=%b exp=%b", e, got, exp);
            end
            if (rc < 0 && buttons_clean[0]) rc = e;
            if (cr < 0 && core_rst) cr = e;
            if (rc >= 0 && fc < 0 && !buttons_clean[0]) fc = e;
            if (cr >= 0 && cf < 0 && !core_rst) cf = e;
        end
        checks++;
        if (rc !== D + 1 || cr - rc !== 1) begin
            failures++; $display("FAIL btnrst_rise clean_at=%0d core_at=%0d exp=%0d/%0d", rc, cr, D + 1, D + 2);
        end
        checks++;
        if (fc < 0 || cf - fc !== R + 1) begin
            failures++; $display("FAIL btnrst_fall clean_fall=%0d core_fall=%0d exp_gap=%0d", fc, cf, R + 1);
        end
    endtask

    task automatic test_async_reset();
        logic [6:0] got, exp;
        buttons_raw = 2'b10;
        repeat (4) cycle();
        #2 rst = 1'b0;
        #1;
        got = {buttons_clean, pressed, released, core_rst};
        checks++;
        if (got !== 7'b0000001) begin
            failures++; $display("FAIL async_mid_debounce got=%b exp=%b", got, 7'b0000001);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int e = 0; e < 8; e++) begin
            cycle();
            got = {buttons_clean, pressed, released, core_rst};
            exp = {m_clean, m_pressed, m_released, m_core};
            checks++;
            if (got !== exp) begin
                failures++; $display("FAIL async_restart cyc=%0d got=%b exp=%b", e, got, exp);
            end
        end
        buttons_raw = 2'b01;
        repeat (9) cycle();
        checks++;
        if ({buttons_clean[0], core_rst} !== 2'b11) begin
            failures++; $display("FAIL async_enter_btn clean0/core=%b%b exp=11", buttons_clean[0], core_rst);
        end
        #2 rst = 1'b0;
        #1;
        got = {buttons_clean, pressed, released, core_rst};
        checks++;
        if (got !== 7'b0000001) begin
            failures++; $display("FAIL async_mid_btn got=%b exp=%b", got, 7'b0000001);
        end
        @(negedge clk);
        buttons_raw = 2'b00; rst = 1'b1;
        model_reset();
        for (int e = 0; e < 6; e++) begin
            cycle();
            got = {buttons_clean, pressed, released, core_rst};
            exp = {m_clean, m_pressed, m_released, m_core};
            checks++;
            if (got !== exp) begin
                failures++; $display("FAIL async_rehold cyc=%0d got=%b exp=%b", e, got, exp);
            end
        end
    endtask

    task automatic test_independence();
        logic [6:0] got, exp;
        for (int e = 0; e < 24; e++) begin
            buttons_raw = (e < 10) ? 2'b11 : 2'b00;
            cycle();
            got = {buttons_clean, pressed, released, core_rst};
            exp = {m_clean, m_pressed, m_released, m_core};
            checks++;
            if (got !== exp || pressed[0] !== pressed[1] || released[0] !== released[1]) begin
                failures++; $display("FAIL independence cyc=%0d got=%b exp=%b", e, got, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] got, exp;
        int run;
        run = 0;
        for (int e = 0; e < 600; e++) begin
            if (run == 0) begin
                buttons_raw = N'($urandom_range(0, 3));
                run = $urandom_range(1, 7);
            end
            run--;
            cycle();
            got = {buttons_clean, pressed, released, core_rst};
            exp = {m_clean, m_pressed, m_released, m_core};
            checks++;
            if (got !== exp || (pressed & released) !== '0) begin
                failures++; $display("FAIL random cyc=%0d raw=%b got=%b exp=%b", e, buttons_raw, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_button_reset();
        test_async_reset();
        test_independence();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
